mldsa_job_sched: RTL and testbench
==================================

// Module: mldsa_job_sched
// PURPOSE
//  Job sequencer in front of the MLDSA core. Queues host jobs {mode, tag}, then runs them one at a time:
//  issues one start pulse with the job's main_mode and waits for done. Snoops the core output stream to
//  count beats, and returns one completion record {tag, status, beats} per job. Sits between the
//  AXI4-Lite register file and the MLDSA core start/main_mode/done pins.
// PARAMETERS
//  DEPTH        4        command queue entries (power of 2, >=2)
//  TAG_W        8        job tag width
//  BEAT_W       16       output-beat counter width (saturating)
//  TIMEOUT_CYC  1048576  watchdog limit in BUSY cycles (used only with MLDSA_SCHED_TIMEOUT_EN)
// PORTS
//  clk            in   1        clock
//  reset          in   1        synchronous, active-high reset
//  cmd_valid      in   1        command offered
//  cmd_ready      out  1        queue not full
//  cmd_mode       in   2        00 keygen, 01 sign, 10 verify, 11 illegal
//  cmd_tag        in   TAG_W    job identifier, returned unchanged in the completion record
//  cpl_valid      out  1        completion record valid
//  cpl_ready      in   1        completion accepted
//  cpl_tag        out  TAG_W    tag of the completed job
//  cpl_status     out  2        0 OK, 1 BAD_MODE, 2 TIMEOUT, 3 never produced
//  cpl_beats      out  BEAT_W   output beats handshaken during the job
//  cpl_last_seen  out  1        an output beat with tlast was handshaken during the job
//  core_start     out  1        one-cycle start pulse to the core
//  core_mode      out  2        main_mode to the core, held stable from START through BUSY
//  core_done      in   1        core done
//  core_abort     out  1        one-cycle core reset request on timeout
//  mon_valid      in   1        snoop: core output tvalid
//  mon_ready      in   1        snoop: core output tready
//  mon_last       in   1        snoop: core output tlast
//  busy           out  1        FSM not in IDLE, or queue not empty
//  q_level        out  $clog2(DEPTH)+1  command queue occupancy
// BEHAVIOUR
//  Reset: FSM=IDLE, queue emptied. cpl_valid, core_start and core_abort are 0. core_mode is 00.
//   busy is 0, q_level is 0, and all cpl_* outputs are 0. Reset mid-job abandons the job with no completion.
//  Queue: push when cmd_valid&cmd_ready. cmd_ready = !full. Push and pop in the same cycle are legal,
//   including when the queue is full (cmd_ready stays 0 while full). Pointers wrap modulo DEPTH.
//  FSM states: IDLE, START, BUSY, REPORT.
//   IDLE: leaves only if the queue is non-empty and cpl_valid=0. Pops the head and latches mode/tag.
//     It clears the beat counter and last_seen. mode==11 -> REPORT with BAD_MODE and no start pulse.
//     Any other mode -> START.
//   START: core_start=1 for exactly this cycle -> BUSY. core_done is ignored here
//     (a stale level from the previous job).
//   BUSY: every mon_valid&mon_ready adds 1 to beats, saturating at 2^BEAT_W-1.
//     mon_last on a handshake sets last_seen. core_done=1 -> REPORT with OK.
//   REPORT: cpl_valid=1, record held stable until cpl_ready. On handshake -> IDLE, cpl_valid=0
//     on the next cycle.
//  Latency: queued job in IDLE -> core_start 1 cycle later. done -> cpl_valid 1 cycle later.
//   Back-to-back jobs: 2 idle cycles minimum between start pulses plus core time.
//  A beat handshaken in the same cycle as core_done is counted.
// CONFIGURATION
//  MLDSA_SCHED_TIMEOUT_EN defined: a BUSY cycle counter runs. When it reaches TIMEOUT_CYC-1 without
//   done, the block pulses core_abort for 1 cycle and goes to REPORT with TIMEOUT.
//   done in that same cycle wins (OK, no abort).
//  Not defined: no counter, core_abort is tied 0, and BUSY waits for done indefinitely.
// STRUCTURE
//  mldsa_sched_pkg: mode encodings, status codes, FSM state enum.
//  Sub-module mldsa_sched_fifo: synchronous FIFO, DEPTH x (2+TAG_W), with full/empty/level outputs.
//  The FSM, counters and completion register live in the top module.
// TESTING
//  1 Push sign tag=0x5A. Core done 20 cycles after start, 7 beats, last on 7th.
//    -> one start pulse with core_mode=01; completion {5A, OK, 7, last_seen=1}.
//  2 Push mode=11 tag=0x11 -> no core_start; completion {11, BAD_MODE, 0, 0} 2 cycles after push.
//  3 Push 5 jobs with DEPTH=4 and no pops -> cmd_ready=0 after the 4th, q_level=4.
//    Then 4 completions appear in FIFO order.
//  4 Hold cpl_ready=0 with 2 jobs queued -> second start is withheld until the first completion is taken.
//  5 TIMEOUT_EN, TIMEOUT_CYC=16, core never done -> core_abort pulses 16 cycles after START.
//    Completion carries TIMEOUT. Repeat with done on the limit cycle -> OK, no abort.
//  6 Assert reset during BUSY -> next cycle: cmd_ready=1, cpl_valid=0, q_level=0, busy=0.
//    No completion is produced for the abandoned job.

Source files
------------

// File: rtl/mldsa_sched_pkg.sv
// Shared encodings for the MLDSA job sequencer: core modes, completion status codes and FSM states.
package mldsa_sched_pkg;

    typedef enum logic [1:0] {
        MODE_KEYGEN  = 2'b00,
        MODE_SIGN    = 2'b01,
        MODE_VERIFY  = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    // ST_NONE is only ever held internally while a job is in flight; it is never reported.
    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_BAD_MODE = 2'd1,
        ST_TIMEOUT  = 2'd2,
        ST_NONE     = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_REPORT
    } state_e;

    function automatic logic mode_is_legal(input logic [1:0] mode);
        return mode != MODE_ILLEGAL;
    endfunction

endpackage

// File: rtl/mldsa_sched_fifo.sv
// Synchronous command FIFO for the job sequencer; DEPTH must be a power of two so the pointers wrap freely.
module mldsa_sched_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/mldsa_job_sched.sv
// Job sequencer in front of the MLDSA core: queues {mode, tag} jobs, runs them one at a time, returns completion records.
// Optional watchdog enabled by defining MLDSA_SCHED_TIMEOUT_EN.
module mldsa_job_sched
    import mldsa_sched_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 8,
    parameter int BEAT_W      = 16,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_mode,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic                     cpl_valid,
    input  logic                     cpl_ready,
    output logic [TAG_W-1:0]         cpl_tag,
    output logic [1:0]               cpl_status,
    output logic [BEAT_W-1:0]        cpl_beats,
    output logic                     cpl_last_seen,
    output logic                     core_start,
    output logic [1:0]               core_mode,
    input  logic                     core_done,
    output logic                     core_abort,
    input  logic                     mon_valid,
    input  logic                     mon_ready,
    input  logic                     mon_last,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_level
);

    localparam int QW = 2 + TAG_W;

    state_e            state;
    state_e            state_nxt;
    logic              q_full;
    logic              q_empty;
    logic              q_push;
    logic              q_pop;
    logic [QW-1:0]     q_head;
    logic [1:0]        head_mode;
    logic [TAG_W-1:0]  head_tag;
    logic              beat_hs;
    logic              tmo_hit;

    assign q_push    = cmd_valid & cmd_ready;
    assign cmd_ready = ~q_full;
    assign head_mode = q_head[QW-1 -: 2];
    assign head_tag  = q_head[TAG_W-1:0];
    assign beat_hs   = mon_valid & mon_ready;
    assign busy      = (state != S_IDLE) | ~q_empty;

    mldsa_sched_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (QW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .wdata ({cmd_mode, cmd_tag}),
        .pop   (q_pop),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .level (q_level)
    );

`ifdef MLDSA_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmo_cnt;

    // Counts BUSY cycles only; the first BUSY cycle sees zero. A done on the limit cycle wins.
    always_ff @(posedge clk) begin
        if (reset || state != S_BUSY) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == S_BUSY) && (tmo_cnt == TMO_LAST) && !core_done;
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A stale done level from the previous job is ignored in START by construction.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (q_pop) begin
                    state_nxt = mode_is_legal(head_mode) ? S_START : S_REPORT;
                end
            end
            S_START: begin
                state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (core_done || tmo_hit) begin
                    state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                if (cpl_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cpl_valid  = (state == S_REPORT);
        core_start = (state == S_START);
        q_pop      = (state == S_IDLE) && !q_empty && !cpl_valid;
        core_abort = tmo_hit;
    end

    // Completion record doubles as the live job context: tag latched on pop, beats/last accumulated in BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpl_tag       <= '0;
            cpl_status    <= ST_OK;
            cpl_beats     <= '0;
            cpl_last_seen <= 1'b0;
            core_mode     <= MODE_KEYGEN;
        end else if (q_pop) begin
            cpl_tag       <= head_tag;
            cpl_beats     <= '0;
            cpl_last_seen <= 1'b0;
            if (mode_is_legal(head_mode)) begin
                cpl_status <= ST_NONE;
                core_mode  <= head_mode;
            end else begin
                cpl_status <= ST_BAD_MODE;
            end
        end else if (state == S_BUSY) begin
            if (beat_hs) begin
                if (cpl_beats != {BEAT_W{1'b1}}) begin
                    cpl_beats <= cpl_beats + 1'b1;
                end
                if (mon_last) begin
                    cpl_last_seen <= 1'b1;
                end
            end
            if (core_done) begin
                cpl_status <= ST_OK;
            end else if (tmo_hit) begin
                cpl_status <= ST_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_mldsa_job_sched.sv
// Directed bench for mldsa_job_sched: table-driven job vectors plus hand-written queue, backpressure, reset and watchdog sequences.
module tb_mldsa_job_sched;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 8;
    localparam int BEAT_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [TAG_W-1:0]  cmd_tag;
    logic              cpl_valid;
    logic              cpl_ready;
    logic [TAG_W-1:0]  cpl_tag;
    logic [1:0]        cpl_status;
    logic [BEAT_W-1:0] cpl_beats;
    logic              cpl_last_seen;
    logic              core_start;
    logic [1:0]        core_mode;
    logic              core_done;
    logic              core_abort;
    logic              mon_valid;
    logic              mon_ready;
    logic              mon_last;
    logic              busy;
    logic [2:0]        q_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mldsa_job_sched #(
        .DEPTH       (DEPTH),
        .TAG_W       (TAG_W),
        .BEAT_W      (BEAT_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mode      (cmd_mode),
        .cmd_tag       (cmd_tag),
        .cpl_valid     (cpl_valid),
        .cpl_ready     (cpl_ready),
        .cpl_tag       (cpl_tag),
        .cpl_status    (cpl_status),
        .cpl_beats     (cpl_beats),
        .cpl_last_seen (cpl_last_seen),
        .core_start    (core_start),
        .core_mode     (core_mode),
        .core_done     (core_done),
        .core_abort    (core_abort),
        .mon_valid     (mon_valid),
        .mon_ready     (mon_ready),
        .mon_last      (mon_last),
        .busy          (busy),
        .q_level       (q_level)
    );

    typedef struct {
        logic [1:0]        mode;
        logic [TAG_W-1:0]  tag;
        int                done_dly;
        int                nbeats;
        int                last_k;
        logic [1:0]        exp_status;
        logic [BEAT_W-1:0] exp_beats;
        logic              exp_last;
    } vec_t;

    vec_t vecs [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Plays the core for d BUSY cycles: nb handshaken beats first, then valid-only cycles with tlast high.
    task automatic driveCore(input logic [1:0] mode, input int d, input int nb, input int lastk, output int stray);
        stray = 0;
        for (int k = 1; k <= d; k++) begin
            tick;
            mon_valid = 1'b1;
            mon_ready = (k <= nb);
            mon_last  = (k == lastk) || (k > nb);
            core_done = (k == d);
            #1;
            if (core_start !== 1'b0 || core_mode !== mode || core_abort !== 1'b0 || cpl_valid !== 1'b0) begin
                stray++;
            end
        end
        tick;
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        mon_last  = 1'b0;
        core_done = 1'b0;
    endtask

    task automatic handshake(input string name);
        cpl_ready = 1'b1;
        tick;
        cpl_ready = 1'b0;
        checkOutput({name, "_cpl_drop"}, cpl_valid, 1'b0);
    endtask

    task automatic applyStimulus(input int i);
        int n;
        int stray;
        string nm;
        nm = $sformatf("v%0d", i);
        cmd_valid = 1'b1;
        cmd_mode  = vecs[i].mode;
        cmd_tag   = vecs[i].tag;
        #1;
        checkOutput({nm, "_cmd_ready"}, cmd_ready, 1'b1);
        tick;
        cmd_valid = 1'b0;
        if (vecs[i].mode == 2'b11) begin
            checkOutput({nm, "_early"}, {core_start, cpl_valid}, 2'b00);
            tick;
            checkOutput({nm, "_bad_latency"}, {core_start, cpl_valid}, 2'b01);
        end else begin
            n = 0;
            do begin
                tick;
                n++;
            end while (!core_start && n < 8);
            checkOutput({nm, "_start_latency"}, n, 1);
            checkOutput({nm, "_core_mode"}, core_mode, vecs[i].mode);
            core_done = 1'b1;
            driveCore(vecs[i].mode, vecs[i].done_dly, vecs[i].nbeats, vecs[i].last_k, stray);
            checkOutput({nm, "_busy_anomalies"}, stray, 0);
            checkOutput({nm, "_done_to_cpl"}, cpl_valid, 1'b1);
        end
        checkOutput({nm, "_tag"}, cpl_tag, vecs[i].tag);
        checkOutput({nm, "_status"}, cpl_status, vecs[i].exp_status);
        checkOutput({nm, "_beats"}, cpl_beats, vecs[i].exp_beats);
        checkOutput({nm, "_last"}, cpl_last_seen, vecs[i].exp_last);
        handshake(nm);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: actual=hung required=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int stray;
        int cnt;
        int held_bad;
        int n;
        logic [TAG_W-1:0] got [5];

        vecs[0] = '{2'b01, 8'h5A, 20, 7, 7, 2'd0, 4'd7, 1'b1};
        vecs[1] = '{2'b00, 8'h3C, 3, 0, 0, 2'd0, 4'd0, 1'b0};
        vecs[2] = '{2'b10, 8'hA5, 25, 20, 0, 2'd0, 4'd15, 1'b0};
        vecs[3] = '{2'b11, 8'h11, 0, 0, 0, 2'd1, 4'd0, 1'b0};
        vecs[4] = '{2'b01, 8'h77, 5, 5, 3, 2'd0, 4'd5, 1'b1};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'b00;
        cmd_tag   = '0;
        cpl_ready = 1'b0;
        core_done = 1'b0;
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        mon_last  = 1'b0;
        repeat (3) tick;
        reset = 1'b0;
        #1;
        checkOutput("rst_cpl_valid", cpl_valid, 1'b0);
        checkOutput("rst_core_pins", {core_start, core_abort, core_mode}, 4'b0000);
        checkOutput("rst_busy_level", {busy, q_level}, 4'b0000);
        checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
        checkOutput("rst_cpl_record", {cpl_tag, cpl_status, cpl_beats, cpl_last_seen}, 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(i);
        end

        // Fill the queue while a completion is pending, then drain in FIFO order.
        $display("[TB] queue fill and drain");
        cmd_valid = 1'b1;
        cmd_mode  = 2'b11;
        for (int t = 0; t < 5; t++) begin
            cmd_tag = 8'h20 + 8'(t);
            tick;
        end
        cmd_tag = 8'h25;
        #1;
        checkOutput("fill_level", q_level, 3'd4);
        checkOutput("fill_cmd_ready", cmd_ready, 1'b0);
        tick;
        cmd_valid = 1'b0;
        checkOutput("full_push_dropped", q_level, 3'd4);
        checkOutput("fill_blocker", {cpl_valid, cpl_tag}, {1'b1, 8'h20});
        cpl_ready = 1'b1;
        cnt = 0;
        n = 0;
        while (cnt < 5 && n < 40) begin
            if (cpl_valid) begin
                got[cnt] = cpl_tag;
                cnt++;
            end
            tick;
            n++;
        end
        cpl_ready = 1'b0;
        checkOutput("drain_count", cnt, 5);
        for (int t = 0; t < 5; t++) begin
            checkOutput($sformatf("drain_tag%0d", t), got[t], 8'h20 + 8'(t));
        end
        checkOutput("drain_idle", {busy, q_level, cpl_valid}, 5'b0);

        // A pending completion must withhold the next start.
        $display("[TB] completion backpressure");
        cmd_valid = 1'b1;
        cmd_mode  = 2'b01;
        cmd_tag   = 8'h41;
        tick;
        cmd_mode  = 2'b10;
        cmd_tag   = 8'h42;
        tick;
        cmd_valid = 1'b0;
        checkOutput("bp_first_start", {core_start, core_mode}, 3'b101);
        driveCore(2'b01, 3, 0, 0, stray);
        checkOutput("bp_first_busy", stray, 0);
        held_bad = 0;
        for (int t = 0; t < 8; t++) begin
            if (core_start !== 1'b0 || cpl_valid !== 1'b1 || cpl_tag !== 8'h41) held_bad++;
            tick;
        end
        checkOutput("bp_held", held_bad, 0);
        checkOutput("bp_level", q_level, 3'd1);
        cpl_ready = 1'b1;
        tick;
        cpl_ready = 1'b0;
        checkOutput("bp_gap", {core_start, cpl_valid}, 2'b00);
        tick;
        checkOutput("bp_second_start", {core_start, core_mode}, 3'b110);
        driveCore(2'b10, 4, 2, 0, stray);
        checkOutput("bp_second_busy", stray, 0);
        checkOutput("bp_second_rec", {cpl_valid, cpl_tag, cpl_status, cpl_beats, cpl_last_seen}, {1'b1, 8'h42, 2'd0, 4'd2, 1'b0});
        handshake("bp");

`ifdef MLDSA_SCHED_TIMEOUT_EN
        $display("[TB] watchdog");
        cmd_valid = 1'b1;
        cmd_mode  = 2'b01;
        cmd_tag   = 8'h55;
        tick;
        cmd_valid = 1'b0;
        tick;
        checkOutput("tmo_start", core_start, 1'b1);
        cnt = 0;
        n = 0;
        for (int k = 1; k <= 16; k++) begin
            tick;
            #1;
            if (core_abort) begin
                cnt++;
                n = k;
            end
        end
        checkOutput("tmo_abort_count", cnt, 1);
        checkOutput("tmo_abort_cycle", n, 16);
        tick;
        checkOutput("tmo_abort_drop", core_abort, 1'b0);
        checkOutput("tmo_rec", {cpl_valid, cpl_tag, cpl_status}, {1'b1, 8'h55, 2'd2});
        handshake("tmo");
        cmd_valid = 1'b1;
        cmd_tag   = 8'h56;
        tick;
        cmd_valid = 1'b0;
        tick;
        checkOutput("tmo2_start", core_start, 1'b1);
        driveCore(2'b01, 16, 0, 0, stray);
        checkOutput("tmo2_no_abort", stray, 0);
        checkOutput("tmo2_rec", {cpl_valid, cpl_tag, cpl_status}, {1'b1, 8'h56, 2'd0});
        handshake("tmo2");
`endif

        // Reset mid-job abandons the running job and the queued one.
        $display("[TB] reset during busy");
        cmd_valid = 1'b1;
        cmd_mode  = 2'b01;
        cmd_tag   = 8'h66;
        tick;
        cmd_tag   = 8'h67;
        tick;
        cmd_valid = 1'b0;
        checkOutput("rb_start", core_start, 1'b1);
        tick;
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        tick;
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        checkOutput("rb_after", {cmd_ready, cpl_valid, q_level, busy}, {1'b1, 1'b0, 3'd0, 1'b0});
        checkOutput("rb_beats", cpl_beats, 4'd0);
        held_bad = 0;
        for (int t = 0; t < 10; t++) begin
            tick;
            if (cpl_valid !== 1'b0 || core_start !== 1'b0) held_bad++;
        end
        checkOutput("rb_no_completion", held_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
